// File: rtl/censor_uart_tx.sv
// UART transmitter (8N1, LSB first) with byte FIFO at the output of the censor pipeline.
// Define CENSOR_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module censor_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [7:0]                       char_in,
    input  logic                             data_ready,
    output logic                             tx,
    output logic                             busy,
    output logic                             fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow
);

    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);

`ifdef CENSOR_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          r_state;
    state_t          w_next_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [2:0]      w_next_bit;
    logic [7:0]      r_shift;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [LW-1:0]   w_level_next;
    logic            r_full;
    logic            r_overflow;
    logic            r_tx;
    logic            r_busy;
    logic            w_tx_next;
    logic            w_busy_next;
    logic            w_empty;
    logic            w_baud_done;
    logic            w_push;
    logic            w_pop;

    assign w_empty     = (r_level == '0);
    assign w_baud_done = (r_baud == BW'(CLKS_PER_BIT - 1));
    // Fullness is the registered flag, so a push into a full FIFO drops even if a pop coincides.
    assign w_push      = data_ready && !r_full;
    assign w_pop       = (w_next_state == S_START) && (r_state != S_START);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty && enable) w_next_state = S_START;
            S_START:  if (w_baud_done) w_next_state = S_DATA;
`ifdef CENSOR_TX_PARITY_EN
            S_DATA:   if (w_baud_done && r_bit == 3'd7) w_next_state = S_PARITY;
            S_PARITY: if (w_baud_done) w_next_state = S_STOP;
`else
            S_DATA:   if (w_baud_done && r_bit == 3'd7) w_next_state = S_STOP;
`endif
            S_STOP:   if (w_baud_done) w_next_state = (!w_empty && enable) ? S_START : S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    assign w_next_bit = (r_state == S_DATA) ? (w_baud_done ? r_bit + 3'd1 : r_bit) : 3'd0;

    // tx/busy are computed from the next state and registered, so the line never glitches.
    always_comb begin
        w_tx_next   = 1'b1;
        w_busy_next = (w_next_state != S_IDLE);
        case (w_next_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shift[w_next_bit];
`ifdef CENSOR_TX_PARITY_EN
            S_PARITY: w_tx_next = ^r_shift;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
            r_baud <= '0;
            r_bit  <= '0;
        end else begin
            r_tx   <= w_tx_next;
            r_busy <= w_busy_next;
            r_baud <= (r_state == S_IDLE || w_baud_done) ? '0 : r_baud + BW'(1);
            r_bit  <= w_next_bit;
        end
    end

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= char_in;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_shift    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_shift  <= r_mem[r_rd_ptr];
            end
            r_level <= w_level_next;
            r_full  <= (w_level_next == LW'(FIFO_DEPTH));
            if (data_ready && r_full) r_overflow <= 1'b1;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = r_full;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_censor_uart_tx.sv
// Directed bench for censor_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4); honours CENSOR_TX_PARITY_EN.
module tb_censor_uart_tx;

    localparam int CPB = 4;
`ifdef CENSOR_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic [7:0] char_in = '0;
    logic       data_ready = 1'b0;
    logic       tx, busy, fifo_full, overflow;
    logic [2:0] fifo_level;

    int n_vec = 0;
    int n_err = 0;

    censor_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clock(clk), .reset(rst_n), .enable(enable), .char_in(char_in),
        .data_ready(data_ready), .tx(tx), .busy(busy), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        data_ready = 1'b1;
        char_in    = d;
        tick();
        data_ready = 1'b0;
    endtask

    // Expected line value for bit slot idx of a frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int unsigned idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef CENSOR_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic frame_cycles(input logic [7:0] d, input int unsigned first,
                                input int unsigned last, input string tag);
        for (int unsigned c = first; c < last; c++) begin
            check(tag, 32'(tx), 32'(frame_bit(d, c / CPB)));
            check({tag, "_busy"}, 32'(busy), 1);
            tick();
        end
    endtask

    task automatic check_idle(input string tag, input logic [2:0] lvl);
        check({tag, "_tx"}, 32'(tx), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_lvl"}, 32'(fifo_level), 32'(lvl));
    endtask

    task automatic send_single(input logic [7:0] d, input string tag);
        push(d);
        check({tag, "_lvl1"}, 32'(fifo_level), 1);
        check({tag, "_pre_tx"}, 32'(tx), 1);
        tick();
        check({tag, "_lvl0"}, 32'(fifo_level), 0);
        frame_cycles(d, 0, FL, tag);
        check_idle({tag, "_end"}, 3'd0);
    endtask

    initial begin
        tick();
        check("rst_tx", 32'(tx), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_full", 32'(fifo_full), 0);
        check("rst_lvl", 32'(fifo_level), 0);
        check("rst_ovf", 32'(overflow), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check_idle("post_rst", 3'd0);

        // single frame 0x41
        send_single(8'h41, "s41");

        // burst of six strobes: the first pops at once, level reaches 4, the sixth drops
        push(8'h2A);
        check("b_lvl_a", 32'(fifo_level), 1);
        push(8'h61);
        check("b_lvl_b", 32'(fifo_level), 1);
        check("b_start", 32'(tx), 0);
        push(8'h62);
        check("b_lvl_c", 32'(fifo_level), 2);
        push(8'h63);
        check("b_lvl_d", 32'(fifo_level), 3);
        push(8'h64);
        check("b_lvl_e", 32'(fifo_level), 4);
        check("b_full", 32'(fifo_full), 1);
        check("b_ovf_pre", 32'(overflow), 0);
        push(8'h65);
        check("b_lvl_drop", 32'(fifo_level), 4);
        check("b_ovf", 32'(overflow), 1);
        frame_cycles(8'h2A, 4, FL, "b2a");
        check("b_lvl3", 32'(fifo_level), 3);
        frame_cycles(8'h61, 0, FL, "b61");
        check("b_lvl2", 32'(fifo_level), 2);
        frame_cycles(8'h62, 0, FL, "b62");
        check("b_lvl1", 32'(fifo_level), 1);
        frame_cycles(8'h63, 0, FL, "b63");
        check("b_lvl0", 32'(fifo_level), 0);
        frame_cycles(8'h64, 0, FL, "b64");
        check_idle("b_end", 3'd0);
        check("b_ovf_sticky", 32'(overflow), 1);

        // enable dropped 10 cycles into a frame with two bytes queued
        push(8'hA5);
        push(8'h5A);
        check("e_start", 32'(tx), 0);
        push(8'hC3);
        check("e_lvl2", 32'(fifo_level), 2);
        frame_cycles(8'hA5, 1, 10, "ea5a");
        enable = 1'b0;
        frame_cycles(8'hA5, 10, FL, "ea5b");
        for (int i = 0; i < 6; i++) begin
            check_idle("e_hold", 3'd2);
            tick();
        end
        enable = 1'b1;
        tick();
        check("e_lvl1", 32'(fifo_level), 1);
        frame_cycles(8'h5A, 0, FL, "e5a");
        check("e_lvl0", 32'(fifo_level), 0);
        frame_cycles(8'hC3, 0, FL, "ec3");
        check_idle("e_end", 3'd0);

        // reset mid-DATA with three bytes queued
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("r_lvl3", 32'(fifo_level), 3);
        frame_cycles(8'h11, 2, 10, "r11");
        rst_n = 1'b0;
        #1;
        check("r_tx", 32'(tx), 1);
        check("r_busy", 32'(busy), 0);
        check("r_lvl", 32'(fifo_level), 0);
        check("r_full", 32'(fifo_full), 0);
        check("r_ovf", 32'(overflow), 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            check_idle("r_quiet", 3'd0);
        end

        // push lands on the STOP->START edge at level 2
        push(8'h9C);
        push(8'h3E);
        push(8'hE7);
        check("p_lvl2", 32'(fifo_level), 2);
        frame_cycles(8'h9C, 1, FL - 1, "p9c");
        check("p_stop", 32'(tx), 1);
        push(8'h81);
        check("p_lvl_same", 32'(fifo_level), 2);
        frame_cycles(8'h3E, 0, FL, "p3e");
        check("p_lvl1", 32'(fifo_level), 1);
        frame_cycles(8'hE7, 0, FL, "pe7");
        check("p_lvl0", 32'(fifo_level), 0);
        frame_cycles(8'h81, 0, FL, "p81");
        check_idle("p_end", 3'd0);

        // parity corner bytes (plain 8N1 frames when parity is not compiled in)
        send_single(8'h03, "s03");
        send_single(8'h07, "s07");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
